// File: rtl/inv_round_key_sched.sv
// inv_round_key_sched
//   Sequencing controller for the AES inverse cipher datapath. It holds the
//   expanded round keys and walks the external inverse round logic from round
//   NR down to 0 for each accepted ciphertext block.
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   key_wr_en/_idx/_data       key store write; accepted only in IDLE, idx <= NR
//   key_err                    one-cycle pulse, one cycle after a rejected write
//   in_valid / in_ready        ciphertext block handshake
//   abort                      synchronous cancel of the block in flight
//   subkey, round_idx          round key and round number for this cycle
//   sel_init                   1 = external block into add-round-key
//   skip_imc                   1 = bypass InvMixColumns (last round)
//   ld_state                   load enable for the datapath state register
//   out_valid / out_ready      plaintext handshake
module inv_round_key_sched #(
  parameter int NR = 10,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_wr_en,
  input  logic [KW-1:0] key_wr_idx,
  input  logic [127:0]  key_wr_data,
  output logic          key_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          abort,
  output logic [127:0]  subkey,
  output logic [KW-1:0] round_idx,
  output logic          sel_init,
  output logic          skip_imc,
  output logic          ld_state,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int            AW   = $clog2(NR + 1);
  localparam logic [KW-1:0] NR_K = KW'(NR);
  localparam logic [KW-1:0] ONE  = KW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   round_q, round_d;
  logic            sel_init_q, sel_init_d;
  logic            skip_imc_q, skip_imc_d;
  logic            ld_state_q, ld_state_d;
  logic            out_valid_q, out_valid_d;
  logic            key_err_q, key_err_d;
  logic [NR:0]     key_valid_q;
  logic [127:0]    key_mem_q [NR+1];
  logic            wr_ok;

  assign wr_ok     = key_wr_en && (state_q == S_IDLE) && (key_wr_idx <= NR_K);
  assign key_err_d = key_wr_en && ((state_q != S_IDLE) || (key_wr_idx > NR_K));

  // A key write in the same cycle blocks acceptance so a block never starts
  // against a half-updated schedule.
  assign in_ready  = (state_q == S_IDLE) && (&key_valid_q) && !key_wr_en;

  always_comb begin
    state_d     = state_q;
    round_d     = '0;
    sel_init_d  = 1'b0;
    skip_imc_d  = 1'b0;
    ld_state_d  = 1'b0;
    out_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE:  if (in_valid && in_ready) state_d = S_INIT;
      S_INIT:  state_d = S_ROUND;
      S_ROUND: if (round_q == ONE) state_d = S_FINAL;
      S_FINAL: state_d = S_HOLD;
      S_HOLD:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;

    // Controls are decoded for the state being entered and registered, so
    // they line up with that state's cycle. round_q is NR in INIT, so the
    // decrement covers both INIT->ROUND and ROUND->ROUND.
    unique case (state_d)
      S_INIT: begin
        round_d    = NR_K;
        sel_init_d = 1'b1;
        ld_state_d = 1'b1;
      end
      S_ROUND: begin
        round_d    = round_q - ONE;
        ld_state_d = 1'b1;
      end
      S_FINAL: begin
        skip_imc_d = 1'b1;
        ld_state_d = 1'b1;
      end
      S_HOLD:  out_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      round_q     <= '0;
      sel_init_q  <= 1'b0;
      skip_imc_q  <= 1'b0;
      ld_state_q  <= 1'b0;
      out_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      key_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      sel_init_q  <= sel_init_d;
      skip_imc_q  <= skip_imc_d;
      ld_state_q  <= ld_state_d;
      out_valid_q <= out_valid_d;
      key_err_q   <= key_err_d;
      if (wr_ok) key_valid_q[key_wr_idx[AW-1:0]] <= 1'b1;
    end
  end

  // Key contents need no reset; the valid mask alone gates use.
  always_ff @(posedge clk) begin
    if (wr_ok) key_mem_q[key_wr_idx[AW-1:0]] <= key_wr_data;
  end

  assign subkey    = ld_state_q ? key_mem_q[round_q[AW-1:0]] : '0;
  assign round_idx = round_q;
  assign sel_init  = sel_init_q;
  assign skip_imc  = skip_imc_q;
  assign ld_state  = ld_state_q;
  assign out_valid = out_valid_q;
  assign key_err   = key_err_q;

endmodule

// File: tb/tb_inv_round_key_sched.sv
module tb_inv_round_key_sched;
  localparam int NR = 10;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          key_wr_en;
  logic [KW-1:0] key_wr_idx;
  logic [127:0]  key_wr_data;
  logic          key_err;
  logic          in_valid;
  logic          in_ready;
  logic          abort;
  logic [127:0]  subkey;
  logic [KW-1:0] round_idx;
  logic          sel_init;
  logic          skip_imc;
  logic          ld_state;
  logic          out_valid;
  logic          out_ready;

  inv_round_key_sched #(.NR(NR), .KW(KW)) dut (
    .clk(clk), .rst(rst),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .key_err(key_err),
    .in_valid(in_valid), .in_ready(in_ready), .abort(abort),
    .subkey(subkey), .round_idx(round_idx), .sel_init(sel_init),
    .skip_imc(skip_imc), .ld_state(ld_state),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- AES reference (byte i = bits [127-8i -: 8]) ----------
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];

  function automatic logic [7:0] xt(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] p = 8'h01;
    logic [7:0] inv, s;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      p = p ^ xt(p);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = x[7:0];
    end
  endtask

  function automatic logic [127:0] sub_b(logic [127:0] s, bit inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv ? isbox[s[127-8*i -: 8]] : sbox[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] shr(logic [127:0] s, bit inv);
    logic [127:0] r;
    int src;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) begin
        src = inv ? (c - rw + 4) % 4 : (c + rw) % 4;
        r[127-8*(4*c+rw) -: 8] = s[127-8*(4*src+rw) -: 8];
      end
    return r;
  endfunction

  function automatic logic [127:0] mix(logic [127:0] s, bit inv);
    logic [127:0] r;
    logic [7:0]   m [4];
    logic [7:0]   acc;
    if (inv) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gm(m[(k - rw + 4) % 4], s[127-8*(4*c+k) -: 8]);
        r[127-8*(4*c+rw) -: 8] = acc;
      end
    return r;
  endfunction

  logic [127:0] rk_exp    [NR+1];
  logic [127:0] key_model [NR+1];

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [4*(NR+1)];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(logic [127:0] p);
    logic [127:0] s = p ^ rk_exp[0];
    for (int r = 1; r < NR; r++) s = mix(shr(sub_b(s, 0), 0), 0) ^ rk_exp[r];
    return shr(sub_b(s, 0), 0) ^ rk_exp[NR];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- inverse datapath driven by the controller -------------
  logic [127:0] ct_in = '0;
  logic [127:0] dp_q  = '0;
  always @(posedge clk) begin
    if (ld_state) begin
      if (sel_init)      dp_q <= ct_in ^ subkey;
      else if (skip_imc) dp_q <= sub_b(shr(dp_q, 1), 1) ^ subkey;
      else               dp_q <= mix(sub_b(shr(dp_q, 1), 1) ^ subkey, 1);
    end
  end

  // ---------------- scoreboard / monitor ----------------------------------
  typedef struct {
    logic [127:0] pt;
    int           t;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  bit   seen = 1'b0;

  always @(negedge clk) begin
    if (rst || !out_valid) begin
      seen = 1'b0;
    end else begin
      chk("ld_state_in_hold", ld_state, 0);
      if (!seen) begin
        seen = 1'b1;
        if (sb_q.size() == 0) chk("unexpected_out_valid", out_valid, 0);
        else chk("latency", cyc - sb_q[0].t, NR + 2);
      end
      if (out_ready && sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("plaintext", dp_q, mon_e.pt);
      end
    end
    if (!rst && ld_state) chk("subkey", subkey, key_model[round_idx]);
  end

  // ---------------- driver tasks (inputs change #1 after posedge) ---------
  task automatic load_keys(input int n);
    for (int i = 0; i < n; i++) begin
      key_wr_en = 1'b1; key_wr_idx = KW'(i); key_wr_data = rk_exp[i];
      @(posedge clk); #1;
      key_model[i] = rk_exp[i];
    end
    key_wr_en = 1'b0;
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt);
    bit   ok = 1'b0;
    exp_t e;
    ct_in = ct;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.pt = pt; e.t = cyc;
        sb_q.push_back(e);
        ok = 1'b1;
      end
    end
    if (!ok) chk("send_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic wait_round(input int r);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (ld_state && round_idx == KW'(r)) ok = 1'b1;
    end
    if (!ok) chk("wait_round_timeout", round_idx, r);
  endtask

  task automatic run(input logic [127:0] ct, input logic [127:0] pt, input int stall);
    out_ready = (stall == 0);
    send(ct, pt);
    wait_ov();
    if (stall != 0) begin
      repeat (stall) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_random(input int n);
    logic [127:0] p;
    for (int i = 0; i < n; i++) begin
      p = rnd128();
      run(encrypt(p), p, $urandom_range(0, 3));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p;
    int           bad_idx [3];
    bad_idx[0] = NR + 1; bad_idx[1] = 12; bad_idx[2] = 15;

    rst = 1'b1; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    for (int i = 0; i <= NR; i++) key_model[i] = '0;
    build_sbox();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ld_state", ld_state, 0);
    chk("rst_subkey", subkey, 0);
    chk("rst_round_idx", round_idx, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_sel_init", sel_init, 0);
    chk("rst_skip_imc", skip_imc, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // partial key set blocks acceptance; completing it opens in_ready
    expand(128'h000102030405060708090a0b0c0d0e0f);
    load_keys(NR);
    ct_in = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    in_valid = 1'b1;
    repeat (3) begin @(negedge clk); chk("in_ready_partial_keys", in_ready, 0); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    key_wr_en = 1'b1; key_wr_idx = KW'(NR); key_wr_data = rk_exp[NR];
    @(negedge clk);
    chk("in_ready_during_write", in_ready, 0);
    @(posedge clk); #1;
    key_wr_en = 1'b0;
    key_model[NR] = rk_exp[NR];
    @(negedge clk);
    chk("in_ready_keys_complete", in_ready, 1);
    chk("key_err_last_key", key_err, 0);
    @(posedge clk); #1;

    // known-answer block
    run(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 0);

    // key write during ROUND is rejected and does not disturb the schedule
    p = rnd128();
    out_ready = 1'b1;
    send(encrypt(p), p);
    wait_round(5);
    key_wr_en = 1'b1; key_wr_idx = KW'(3); key_wr_data = rnd128();
    @(posedge clk); #1;
    key_wr_en = 1'b0;
    @(negedge clk); chk("key_err_busy_pulse", key_err, 1);
    @(negedge clk); chk("key_err_busy_clear", key_err, 0);
    wait_ov();
    @(posedge clk); #1;

    // out-of-range indices in IDLE
    for (int i = 0; i < 3; i++) begin
      key_wr_en = 1'b1; key_wr_idx = KW'(bad_idx[i]); key_wr_data = rnd128();
      @(posedge clk); #1;
      key_wr_en = 1'b0;
      @(negedge clk);
      chk("key_err_range_pulse", key_err, 1);
      chk("in_ready_after_bad_write", in_ready, 1);
      @(negedge clk);
      chk("key_err_range_clear", key_err, 0);
      @(posedge clk); #1;
    end
    run_random(2);

    // downstream stall in HOLD
    p = rnd128();
    out_ready = 1'b0;
    send(encrypt(p), p);
    wait_ov();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_ld_state", ld_state, 0);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // abort mid-block
    p = rnd128();
    send(encrypt(p), p);
    wait_round(6);
    abort = 1'b1;
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_ld_state", ld_state, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_round_idx", round_idx, 0);
    chk("abort_in_ready", in_ready, 1);
    repeat (NR + 4) @(negedge clk);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_in_ready", in_ready, 1);
    chk("idle_abort_ld_state", ld_state, 0);
    @(posedge clk); #1;
    run_random(6);

    // async reset mid-block clears the key mask
    p = rnd128();
    send(encrypt(p), p);
    wait_round(4);
    rst = 1'b1;
    #1;
    chk("arst_ld_state", ld_state, 0);
    chk("arst_subkey", subkey, 0);
    chk("arst_round_idx", round_idx, 0);
    chk("arst_sel_init", sel_init, 0);
    chk("arst_in_ready", in_ready, 0);
    sb_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin @(negedge clk); chk("arst_no_keys_in_ready", in_ready, 0); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    expand(rnd128());
    load_keys(NR + 1);
    @(negedge clk);
    chk("reload_in_ready", in_ready, 1);
    @(posedge clk); #1;
    run_random(4);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
